// File: rtl/mult_scheduler_pkg.sv
// Shared constants for the HI/LO multiply scheduler: op codes, FSM states, default width.
package mult_scheduler_pkg;

  localparam int MS_WIDTH = 32;

  localparam logic [2:0] HL_NOP   = 3'd0;
  localparam logic [2:0] HL_MULT  = 3'd1;
  localparam logic [2:0] HL_MULTU = 3'd2;
  localparam logic [2:0] HL_MFHI  = 3'd3;
  localparam logic [2:0] HL_MFLO  = 3'd4;
  localparam logic [2:0] HL_MTHI  = 3'd5;
  localparam logic [2:0] HL_MTLO  = 3'd6;
  localparam logic [2:0] HL_MADD  = 3'd7;

  typedef enum logic [1:0] {
    MS_IDLE     = 2'd0,
    MS_WAIT_RDY = 2'd1,
    MS_BUSY     = 2'd2
  } ms_state_e;

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO register pair with per-half writes and a full product load.
// MULT_ACCUM_EN adds the accumulate path used by MADD.
module hilo_reg
  import mult_scheduler_pkg::*;
#(
  parameter int WIDTH = MS_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_wr_hi,
  input  logic               i_wr_lo,
  input  logic               i_load,
`ifdef MULT_ACCUM_EN
  input  logic               i_accum,
`endif
  input  logic [WIDTH-1:0]   i_wdata,
  input  logic [2*WIDTH-1:0] i_product,
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo
);

  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [2*WIDTH-1:0] w_load_val;

`ifdef MULT_ACCUM_EN
  // Sum wraps at 2*WIDTH bits; the carry out of HI is intentionally dropped.
  logic [2*WIDTH-1:0] w_sum;
  assign w_sum      = {r_hi, r_lo} + i_product;
  assign w_load_val = i_accum ? w_sum : i_product;
`else
  assign w_load_val = i_product;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= {WIDTH{1'b0}};
      r_lo <= {WIDTH{1'b0}};
    end else if (i_load) begin
      r_hi <= w_load_val[2*WIDTH-1:WIDTH];
      r_lo <= w_load_val[WIDTH-1:0];
    end else begin
      if (i_wr_hi) r_hi <= i_wdata;
      if (i_wr_lo) r_lo <= i_wdata;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/mult_scheduler.sv
// Execute-stage multiply scheduler: start/stall control and HI/LO ownership.
// Define MULT_ACCUM_EN to enable op 7 (MADD, signed multiply-accumulate).
module mult_scheduler
  import mult_scheduler_pkg::*;
#(
  parameter int WIDTH = MS_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_e,
  input  logic [2:0]         op_e,
  input  logic [WIDTH-1:0]   mt_data,
  input  logic               mult_ready,
  input  logic               mult_done,
  input  logic [2*WIDTH-1:0] product,
  output logic               start_mult,
  output logic               mult_sign,
  output logic               stall_mult,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  ms_state_e r_state;
  logic      w_is_mul;
  logic      w_is_hilo;
  logic      w_start;
  logic      w_stall;
  logic      w_sign;
  logic      w_load;
  logic      w_wr_hi;
  logic      w_wr_lo;

`ifdef MULT_ACCUM_EN
  logic r_madd;
  assign w_is_mul  = valid_e && ((op_e == HL_MULT) || (op_e == HL_MULTU) || (op_e == HL_MADD));
  assign w_is_hilo = valid_e && (op_e != HL_NOP);
  assign w_sign    = (op_e == HL_MULT) || (op_e == HL_MADD);
`else
  // Without accumulate support op 7 behaves as a NOP and never stalls.
  assign w_is_mul  = valid_e && ((op_e == HL_MULT) || (op_e == HL_MULTU));
  assign w_is_hilo = valid_e && (op_e != HL_NOP) && (op_e != HL_MADD);
  assign w_sign    = (op_e == HL_MULT);
`endif

  always_comb begin
    w_start = 1'b0;
    w_stall = 1'b0;
    case (r_state)
      MS_IDLE, MS_WAIT_RDY: begin
        if (w_is_mul) begin
          if (mult_ready) w_start = 1'b1;
          else            w_stall = 1'b1;
        end else begin
          w_start = 1'b0;
        end
      end
      MS_BUSY: w_stall = w_is_hilo;
      default: begin
        w_start = 1'b0;
        w_stall = 1'b0;
      end
    endcase
  end

  assign w_load  = (r_state == MS_BUSY) && mult_done;
  assign w_wr_hi = (r_state == MS_IDLE) && valid_e && (op_e == HL_MTHI);
  assign w_wr_lo = (r_state == MS_IDLE) && valid_e && (op_e == HL_MTLO);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MS_IDLE;
`ifdef MULT_ACCUM_EN
      r_madd  <= 1'b0;
`endif
    end else begin
      case (r_state)
        MS_IDLE, MS_WAIT_RDY: begin
          if (w_start)        r_state <= MS_BUSY;
          else if (w_is_mul)  r_state <= MS_WAIT_RDY;
          else                r_state <= MS_IDLE;
        end
        MS_BUSY: begin
          if (mult_done) r_state <= MS_IDLE;
          else           r_state <= MS_BUSY;
        end
        default: r_state <= MS_IDLE;
      endcase
`ifdef MULT_ACCUM_EN
      // Latch MADD at start; op_e is free to change while the multiply runs.
      if (w_start) r_madd <= (op_e == HL_MADD);
      else         r_madd <= r_madd;
`endif
    end
  end

  hilo_reg #(.WIDTH(WIDTH)) u_hilo (
    .clk       (clk),
    .reset     (reset),
    .i_wr_hi   (w_wr_hi),
    .i_wr_lo   (w_wr_lo),
    .i_load    (w_load),
`ifdef MULT_ACCUM_EN
    .i_accum   (r_madd),
`endif
    .i_wdata   (mt_data),
    .i_product (product),
    .o_hi      (hi),
    .o_lo      (lo)
  );

  assign start_mult = w_start;
  assign mult_sign  = w_start && w_sign;
  assign stall_mult = w_stall;
  assign busy       = (r_state == MS_BUSY);

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed bench for mult_scheduler; expected HI/LO results are queued at issue
// and compared when the multiply completes.
module tb_mult_scheduler;
  import mult_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_e;
  logic [2:0]  op_e;
  logic [31:0] mt_data;
  logic        mult_ready;
  logic        mult_done;
  logic [63:0] product;
  logic        start_mult;
  logic        mult_sign;
  logic        stall_mult;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  mult_scheduler #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_e    (valid_e),
    .op_e       (op_e),
    .mt_data    (mt_data),
    .mult_ready (mult_ready),
    .mult_done  (mult_done),
    .product    (product),
    .start_mult (start_mult),
    .mult_sign  (mult_sign),
    .stall_mult (stall_mult),
    .busy       (busy),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $error("FAIL %s: observed empty scoreboard expected one entry", tag);
    end else begin
      chk(tag, {hi, lo}, sb_q.pop_front());
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] d);
    valid_e = v;
    op_e    = op;
    mt_data = d;
  endtask

  initial begin
    reset = 1'b1; mult_ready = 1'b1; mult_done = 1'b0; product = 64'd0;
    drive(1'b0, HL_NOP, 32'd0);
    cyc(); cyc();
    reset = 1'b0;
    settle();
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd1 - 64'd1);
    chk("rst_start", {63'd0, start_mult}, 64'd0);
    chk("rst_stall", {63'd0, stall_mult}, 64'd0);

    // Reset while a MULT 3x5 is in flight; the late done must be ignored
    drive(1'b1, HL_MULT, 32'd0); settle();
    chk("rb_start", {63'd0, start_mult}, 64'd1);
    cyc(); drive(1'b0, HL_NOP, 32'd0); settle();
    chk("rb_busy", {63'd0, busy}, 64'd1);
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0; settle();
    chk("rb_busy_clr", {63'd0, busy}, 64'd0);
    mult_done = 1'b1; product = 64'd15; settle();
    chk("rb_no_stall", {63'd0, stall_mult}, 64'd0);
    cyc(); mult_done = 1'b0; settle();
    chk("rb_hilo", {hi, lo}, 64'd0);
    chk("rb_idle", {63'd0, busy}, 64'd0);

    // MULT -2 x 3, MFLO waits behind it
    drive(1'b1, HL_MULT, 32'd0); settle();
    chk("mf_start", {63'd0, start_mult}, 64'd1);
    chk("mf_sign", {63'd0, mult_sign}, 64'd1);
    chk("mf_nostall", {63'd0, stall_mult}, 64'd0);
    sb_q.push_back(64'hFFFF_FFFF_FFFF_FFFA);
    cyc(); drive(1'b1, HL_MFLO, 32'd0); settle();
    chk("mf_start_once", {63'd0, start_mult}, 64'd0);
    chk("mf_stall1", {63'd0, stall_mult}, 64'd1);
    for (int i = 0; i < 2; i++) begin
      cyc(); settle();
      chk("mf_stall_wait", {63'd0, stall_mult}, 64'd1);
    end
    cyc(); mult_done = 1'b1; product = 64'hFFFF_FFFF_FFFF_FFFA; settle();
    chk("mf_stall_done", {63'd0, stall_mult}, 64'd1);
    cyc(); mult_done = 1'b0; settle();
    chk("mf_release", {63'd0, stall_mult}, 64'd0);
    sb_check("mf_result");

    // MULTU with an independent instruction behind it
    drive(1'b1, HL_MULTU, 32'd0); settle();
    chk("mu_start", {63'd0, start_mult}, 64'd1);
    chk("mu_sign", {63'd0, mult_sign}, 64'd0);
    sb_q.push_back(64'h0000_0001_FFFF_FFFE);
    cyc(); drive(1'b1, HL_NOP, 32'd0); settle();
    chk("mu_busy", {63'd0, busy}, 64'd1);
    chk("mu_nostall", {63'd0, stall_mult}, 64'd0);
    cyc(); mult_done = 1'b1; product = 64'h0000_0001_FFFF_FFFE; settle();
    chk("mu_nostall_done", {63'd0, stall_mult}, 64'd0);
    cyc(); mult_done = 1'b0; drive(1'b0, HL_NOP, 32'd0); settle();
    sb_check("mu_result");
    chk("mu_idle", {63'd0, busy}, 64'd0);

    // Multiplier not ready for 3 cycles, then back-to-back MULTs
    mult_ready = 1'b0; drive(1'b1, HL_MULT, 32'd0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("nr_stall", {63'd0, stall_mult}, 64'd1);
      chk("nr_nostart", {63'd0, start_mult}, 64'd0);
      cyc();
    end
    mult_ready = 1'b1; settle();
    chk("nr_start", {63'd0, start_mult}, 64'd1);
    chk("nr_stall_off", {63'd0, stall_mult}, 64'd0);
    sb_q.push_back(64'd42);
    cyc(); settle();
    chk("nr_single_pulse", {63'd0, start_mult}, 64'd0);
    chk("b2b_stall", {63'd0, stall_mult}, 64'd1);
    mult_done = 1'b1; product = 64'd42; settle();
    chk("b2b_stall_done", {63'd0, stall_mult}, 64'd1);
    chk("b2b_nostart_done", {63'd0, start_mult}, 64'd0);
    cyc(); mult_done = 1'b0; settle();
    sb_check("b2b_first");
    chk("b2b_idle", {63'd0, busy}, 64'd0);
    chk("b2b_restart", {63'd0, start_mult}, 64'd1);
    sb_q.push_back(64'hFFFF_FFFF_FFFF_FFF9);
    cyc(); drive(1'b0, HL_NOP, 32'd0); mult_done = 1'b1; product = 64'hFFFF_FFFF_FFFF_FFF9; settle();
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    cyc(); mult_done = 1'b0; settle();
    sb_check("b2b_second");

    // MTHI in IDLE, MTLO held behind a MULTU
    drive(1'b1, HL_MTHI, 32'h0000_1234); settle();
    chk("mthi_nostall", {63'd0, stall_mult}, 64'd0);
    cyc(); drive(1'b0, HL_NOP, 32'd0); settle();
    chk("mthi_val", {hi, lo}, 64'h0000_1234_FFFF_FFF9);
    drive(1'b1, HL_MULTU, 32'd0); settle();
    chk("mt_start", {63'd0, start_mult}, 64'd1);
    sb_q.push_back(64'h0000_00AA_0000_00BB);
    cyc(); drive(1'b1, HL_MTLO, 32'h0000_ABCD); settle();
    chk("mtlo_stall", {63'd0, stall_mult}, 64'd1);
    chk("mtlo_hold", {hi, lo}, 64'h0000_1234_FFFF_FFF9);
    cyc(); mult_done = 1'b1; product = 64'h0000_00AA_0000_00BB; settle();
    chk("mtlo_stall_done", {63'd0, stall_mult}, 64'd1);
    cyc(); mult_done = 1'b0; settle();
    chk("mtlo_go", {63'd0, stall_mult}, 64'd0);
    sb_check("mt_result");
    cyc(); drive(1'b0, HL_NOP, 32'd0); settle();
    chk("mtlo_val", {hi, lo}, 64'h0000_00AA_0000_ABCD);

    // Spurious done in IDLE
    mult_done = 1'b1; product = 64'hDEAD_BEEF_0BAD_F00D; settle();
    chk("spur_idle", {63'd0, busy}, 64'd0);
    cyc(); mult_done = 1'b0; settle();
    chk("spur_hilo", {hi, lo}, 64'h0000_00AA_0000_ABCD);

    // MADD 1x1 onto {hi,lo} = 0x1_FFFFFFFF
    drive(1'b1, HL_MTHI, 32'd1); cyc();
    drive(1'b1, HL_MTLO, 32'hFFFF_FFFF); cyc();
    drive(1'b0, HL_NOP, 32'd0); settle();
    chk("madd_pre", {hi, lo}, 64'h0000_0001_FFFF_FFFF);
    drive(1'b1, HL_MADD, 32'd0); settle();
`ifdef MULT_ACCUM_EN
    chk("madd_start", {63'd0, start_mult}, 64'd1);
    chk("madd_sign", {63'd0, mult_sign}, 64'd1);
    sb_q.push_back(64'h0000_0002_0000_0000);
    cyc(); drive(1'b1, HL_MULTU, 32'd0); mult_done = 1'b1; product = 64'd1; settle();
    chk("madd_busy", {63'd0, busy}, 64'd1);
    cyc(); mult_done = 1'b0; drive(1'b0, HL_NOP, 32'd0); settle();
    sb_check("madd_result");
`else
    chk("madd_nostart", {63'd0, start_mult}, 64'd0);
    chk("madd_nostall", {63'd0, stall_mult}, 64'd0);
    cyc(); settle();
    chk("madd_nobusy", {63'd0, busy}, 64'd0);
    chk("madd_nochange", {hi, lo}, 64'h0000_0001_FFFF_FFFF);
    drive(1'b0, HL_NOP, 32'd0);
`endif

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
